// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, arbiter states and NZCV flag record
package alu_pkg;
  localparam int ANCHO_DEF = 32;
  localparam logic [3:0] OP_SUMA  = 4'b0000;
  localparam logic [3:0] OP_RESTA = 4'b0001;
  localparam logic [3:0] OP_OVF   = 4'b0010;
  localparam logic [3:0] OP_CARRY_MIN = 4'b1011;
  typedef enum logic {INACTIVO, EJECUTAR} estado_t;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
endpackage

// File: rtl/calc_banderas.sv
// calc_banderas: combinational NZCV derivation from opcode, ALU result and ALU status
module calc_banderas
  import alu_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [3:0]       sel,
  input  logic [ANCHO-1:0] alu_resultado,
  input  logic             alu_carry,
  input  logic             alu_borrow,
  input  logic             alu_overflow,
  output nzcv_t            banderas
);
  // carry is meaningful for the add code and the upper opcode block only
  always_comb begin
    banderas.n = (sel == OP_RESTA) & alu_borrow;
    banderas.z = (alu_resultado == '0);
    banderas.c = ((sel == OP_SUMA) | (sel >= OP_CARRY_MIN)) & alu_carry;
    banderas.v = (sel == OP_OVF) & alu_overflow;
  end
endmodule

// File: rtl/arbitro_alu.sv
// arbitro_alu: two-requester ALU sequencer with registered result/flags; ARBITRO_ALU_RR_EN selects round-robin
module arbitro_alu
  import alu_pkg::*;
#(
  parameter int ANCHO    = ANCHO_DEF,
  parameter int LATENCIA = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [3:0]       sel0,
  input  logic [3:0]       sel1,
  input  logic [ANCHO-1:0] a0,
  input  logic [ANCHO-1:0] b0,
  input  logic [ANCHO-1:0] a1,
  input  logic [ANCHO-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [ANCHO-1:0] resultado,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic [3:0]       alu_sel,
  output logic [ANCHO-1:0] alu_a,
  output logic [ANCHO-1:0] alu_b,
  input  logic [ANCHO-1:0] alu_resultado,
  input  logic             alu_carry,
  input  logic             alu_borrow,
  input  logic             alu_overflow
);
  estado_t    estado, estado_nx;
  logic [2:0] cnt;
  logic       id, win, acepta, fin;
  nzcv_t      bnd, flags;
`ifdef ARBITRO_ALU_RR_EN
  logic ptr;
  // pointer only matters on contention; a sole requester always wins
  always_comb win = (req == 2'b11) ? ptr : req[1];
  // preference alternates after every grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (acepta) ptr <= ~win;
`else
  // fixed priority: requester 0 wins whenever it asks
  always_comb win = ~req[0];
`endif
  // accept and complete conditions plus next state
  always_comb begin
    acepta    = (estado == INACTIVO) & (|req);
    fin       = (estado == EJECUTAR) & (cnt == 3'd0);
    estado_nx = (estado == INACTIVO) ? (acepta ? EJECUTAR : INACTIVO) : (fin ? INACTIVO : EJECUTAR);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= INACTIVO;
    else estado <= estado_nx;
  // operand latch, latency counter, pulses and registered result/flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt       <= '0;
      done      <= '0;
      cnt       <= '0;
      id        <= 1'b0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      resultado <= '0;
      flags     <= '0;
    end else begin
      gnt  <= acepta ? (2'b01 << win) : 2'b00;
      done <= fin ? (2'b01 << id) : 2'b00;
      if (acepta) begin
        alu_sel <= win ? sel1 : sel0;
        alu_a   <= win ? a1 : a0;
        alu_b   <= win ? b1 : b0;
        cnt     <= 3'(LATENCIA - 1);
        id      <= win;
      end else if (estado == EJECUTAR && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (fin) begin
        resultado <= alu_resultado;
        flags     <= bnd;
      end
    end
  calc_banderas #(.ANCHO(ANCHO)) u_banderas (
    .sel          (alu_sel),
    .alu_resultado(alu_resultado),
    .alu_carry    (alu_carry),
    .alu_borrow   (alu_borrow),
    .alu_overflow (alu_overflow),
    .banderas     (bnd)
  );
  assign N = flags.n;
  assign Z = flags.z;
  assign C = flags.c;
  assign V = flags.v;
endmodule
